// File: rtl/audio_pkg.sv
// Shared audio constants and the mixed-sample type for the I2S output path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package audio_pkg;

    localparam int                FRAME_LEN  = 1024;
    localparam logic [8:0]        MID_SCALE  = 9'd256;

    typedef logic signed [15:0] sample_t;

    localparam sample_t           SAMPLE_MAX = 16'sh7FFF;
    localparam sample_t           SAMPLE_MIN = 16'sh8000;

endpackage

// File: rtl/voice_mix_sat.sv
// Mixes two unsigned 9-bit voices to one signed sample, scaled by volume and saturated.
// Latency: combinational.
// Backpressure: none; output follows inputs.
module voice_mix_sat
    import audio_pkg::*;
(
    input  logic [8:0] stream1_in,
    input  logic [8:0] stream2_in,
    input  logic [2:0] volume,
    input  logic       mute,
    output sample_t    sample_out
);

    // Worst case |sum| << 7 is 65536, which fits an 18-bit signed value.
    localparam logic signed [17:0] SAT_HI = 18'sh07FFF;
    localparam logic signed [17:0] SAT_LO = 18'sh38000;

    logic signed [10:0] s1;
    logic signed [10:0] s2;
    logic signed [10:0] sum;
    logic signed [17:0] sum_ext;
    logic signed [17:0] scaled;

    always_comb begin
        s1         = $signed({2'b00, stream1_in}) - $signed({2'b00, MID_SCALE});
        s2         = $signed({2'b00, stream2_in}) - $signed({2'b00, MID_SCALE});
        sum        = s1 + s2;
        sum_ext    = {{7{sum[10]}}, sum};
        scaled     = sum_ext <<< volume;
        sample_out = scaled[15:0];
        if (mute) begin
            sample_out = '0;
        end else if (scaled > SAT_HI) begin
            sample_out = SAMPLE_MAX;
        end else if (scaled < SAT_LO) begin
            sample_out = SAMPLE_MIN;
        end
    end

endmodule

// File: rtl/note_mixer_i2s.sv
// Mixes two voice streams once per frame and serialises the result as I2S; derives codec clocks.
// Latency: inputs latched at cnt==1023, MSB on DACDAT one BCLK into the next frame's channel.
// Backpressure: none; sample_req paces upstream once per 1024-clk frame.
module note_mixer_i2s
    import audio_pkg::*;
#(
    parameter int SAMPLE_W  = 16,
    parameter int SLOT_BITS = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [8:0] NoteStream1_in,
    input  logic [8:0] NoteStream2_in,
    input  logic [2:0] volume,
    input  logic       mute,
    output logic       AUD_MCLK,
    output logic       AUD_BCLK,
    output logic       AUD_DACLRCK,
    output logic       AUD_DACDAT,
    output logic       sample_req
);

    localparam int                CNT_W     = $clog2(FRAME_LEN);
    localparam int                SLOT_W    = $clog2(SLOT_BITS);
    localparam int                BIT_W     = $clog2(SAMPLE_W);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SAMPLE_W);

    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    sample_t           sample_reg_q;
    sample_t           sample_reg_d;
    sample_t           mix_sample;
    logic              dat_q;
    logic              dat_d;
    logic              frame_end;
    logic [SLOT_W-1:0] slot_d;
    logic [BIT_W-1:0]  bit_idx;

    voice_mix_sat u_mix (
        .stream1_in (NoteStream1_in),
        .stream2_in (NoteStream2_in),
        .volume     (volume),
        .mute       (mute),
        .sample_out (mix_sample)
    );

    assign frame_end = (cnt_q == '1);

    // Next data bit is chosen for the slot being entered, so DACDAT moves with BCLK falling.
    always_comb begin
        cnt_d        = cnt_q + CNT_W'(1);
        sample_reg_d = frame_end ? mix_sample : sample_reg_q;
        slot_d       = cnt_d[4 +: SLOT_W];
        bit_idx      = BIT_W'(SAMPLE_W - 1) - BIT_W'(slot_d - SLOT_W'(1));
        dat_d        = dat_q;
        if (cnt_d[3:0] == 4'd0) begin
            dat_d = en && (slot_d != '0) && (slot_d <= LAST_SLOT) && sample_reg_q[bit_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q        <= '0;
            sample_reg_q <= '0;
            dat_q        <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            sample_reg_q <= sample_reg_d;
            dat_q        <= dat_d;
        end
    end

    assign AUD_MCLK    = cnt_q[1];
    assign AUD_BCLK    = cnt_q[3];
    assign AUD_DACLRCK = cnt_q[CNT_W-1];
    assign AUD_DACDAT  = dat_q;
    assign sample_req  = en && frame_end;

endmodule

// File: tb/tb_note_mixer_i2s.sv
// Bench for note_mixer_i2s: frame-position model checked every clk, plus literal serial captures.
module tb_note_mixer_i2s;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [8:0] n1;
    logic [8:0] n2;
    logic [2:0] volume;
    logic       mute;
    logic       AUD_MCLK;
    logic       AUD_BCLK;
    logic       AUD_DACLRCK;
    logic       AUD_DACDAT;
    logic       sample_req;

    int total = 0;
    int bad   = 0;

    note_mixer_i2s dut (
        .clk            (clk),
        .reset          (reset),
        .en             (en),
        .NoteStream1_in (n1),
        .NoteStream2_in (n2),
        .volume         (volume),
        .mute           (mute),
        .AUD_MCLK       (AUD_MCLK),
        .AUD_BCLK       (AUD_BCLK),
        .AUD_DACLRCK    (AUD_DACLRCK),
        .AUD_DACDAT     (AUD_DACDAT),
        .sample_req     (sample_req)
    );

    always #10 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] mix_model(input int a, input int b, input int vol, input bit mu);
        int v;
        v = ((a - 256) + (b - 256)) * (1 << vol);
        if (v > 32767)  v = 32767;
        if (v < -32768) v = -32768;
        if (mu)         v = 0;
        return 16'(v);
    endfunction

    // Model: position within the frame, the latched sample, and the expected data line.
    int          m_pos    = 0;
    bit          m_valid  = 0;
    logic [15:0] m_sample = '0;
    logic        m_dat    = 1'b0;
    int          m_slot;

    always @(posedge clk) begin
        if (reset) begin
            m_pos    = 0;
            m_sample = '0;
            m_dat    = 1'b0;
            m_valid  = 1;
        end else if (m_valid) begin
            if (m_pos == 1023) m_sample = mix_model(int'(n1), int'(n2), int'(volume), mute);
            m_pos = (m_pos + 1) % 1024;
            if (m_pos % 16 == 0) begin
                m_slot = (m_pos % 512) / 16;
                m_dat  = en && m_slot >= 1 && m_slot <= 16 && m_sample[16 - m_slot];
            end
        end
    end

    logic [15:0] cap_l = '0;
    logic [15:0] cap_r = '0;
    int          cap_slot;

    always @(posedge clk) begin
        #1;
        if (m_valid) begin
            chk("mclk",   AUD_MCLK,    (m_pos / 2) % 2);
            chk("bclk",   AUD_BCLK,    (m_pos / 8) % 2);
            chk("lrck",   AUD_DACLRCK, (m_pos / 512) % 2);
            chk("dacdat", AUD_DACDAT,  m_dat);
            chk("req",    sample_req,  en && m_pos == 1023);
            if (m_pos % 16 == 8) begin
                cap_slot = (m_pos % 512) / 16;
                if (cap_slot >= 1 && cap_slot <= 16) begin
                    if (m_pos < 512) cap_l = {cap_l[14:0], AUD_DACDAT};
                    else             cap_r = {cap_r[14:0], AUD_DACDAT};
                end
            end
        end
    end

    task automatic goto_pos(input int p);
        int n;
        n = 0;
        @(negedge clk);
        while (m_pos != p && n < 2100) begin
            @(negedge clk);
            n++;
        end
        if (m_pos != p) begin
            total++;
            bad++;
            $display("FAIL goto_pos timeout actual=%0d required=%0d", m_pos, p);
        end
    endtask

    task automatic check_caps(input string name, input logic [15:0] exp);
        chk({name, "_left"},  cap_l, exp);
        chk({name, "_right"}, cap_r, exp);
    endtask

    typedef struct {
        int          a;
        int          b;
        int          vol;
        bit          mu;
        logic [15:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int n;
        int req_cnt;
        int one_cnt;
        int bclk_tog;
        int lrck_tog;
        logic prev_b;
        logic prev_l;

        vecs[0] = '{511, 511, 0, 1'b0, 16'h01FE, "small_mix"};
        vecs[1] = '{511, 511, 7, 1'b0, 16'h7FFF, "pos_sat"};
        vecs[2] = '{0,   0,   7, 1'b0, 16'h8000, "neg_sat"};
        vecs[3] = '{511, 0,   0, 1'b1, 16'h0000, "mute"};

        reset  = 1'b1;
        en     = 1'b1;
        n1     = 9'd256;
        n2     = 9'd256;
        volume = 3'd0;
        mute   = 1'b0;
        repeat (5) @(negedge clk);
        chk("reset_outputs", {AUD_MCLK, AUD_BCLK, AUD_DACLRCK, AUD_DACDAT, sample_req}, 0);
        reset = 1'b0;

        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!AUD_DACLRCK && n < 600);
        chk("lrck_first_rise_clks", n, 512);
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!sample_req && n < 1100);
        // Pulse occupies the clk period with cnt==1023, the 1024th period after release.
        chk("first_req_edge", n, 1023);

        goto_pos(800);
        check_caps("mid_scale", 16'h0000);

        foreach (vecs[i]) begin
            n1     = 9'(vecs[i].a);
            n2     = 9'(vecs[i].b);
            volume = 3'(vecs[i].vol);
            mute   = vecs[i].mu;
            goto_pos(1023);
            goto_pos(800);
            check_caps(vecs[i].name, vecs[i].exp);
        end

        n1     = 9'd300;
        n2     = 9'd300;
        volume = 3'd0;
        mute   = 1'b0;
        goto_pos(1023);
        goto_pos(500);
        n1 = 9'd200;
        n2 = 9'd200;
        goto_pos(800);
        check_caps("latch_hold", 16'h0058);
        goto_pos(1023);
        goto_pos(800);
        check_caps("latch_next", 16'hFF90);

        goto_pos(1000);
        en       = 1'b0;
        req_cnt  = 0;
        one_cnt  = int'(AUD_DACDAT);
        bclk_tog = 0;
        lrck_tog = 0;
        prev_b   = AUD_BCLK;
        prev_l   = AUD_DACLRCK;
        for (int i = 0; i < 1024; i++) begin
            @(negedge clk);
            if (sample_req)            req_cnt++;
            if (AUD_DACDAT)            one_cnt++;
            if (AUD_BCLK != prev_b)    bclk_tog++;
            if (AUD_DACLRCK != prev_l) lrck_tog++;
            prev_b = AUD_BCLK;
            prev_l = AUD_DACLRCK;
        end
        chk("en0_req_pulses", req_cnt, 0);
        chk("en0_dacdat_ones", one_cnt, 0);
        chk("en0_bclk_toggles", bclk_tog, 128);
        chk("en0_lrck_toggles", lrck_tog, 2);
        en = 1'b1;

        goto_pos(300);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("midframe_reset_outputs", {AUD_MCLK, AUD_BCLK, AUD_DACLRCK, AUD_DACDAT, sample_req}, 0);
        reset = 1'b0;
        goto_pos(800);
        check_caps("post_reset_sample", 16'h0000);
        goto_pos(1023);
        goto_pos(800);
        check_caps("post_reset_next", 16'hFF90);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
